// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS multicycle control definitions: opcodes, ALU op codes, state encoding, control bundle.
// Macro MIPS_BNE_EN adds the bne opcode and its BRANCHNE state.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
`ifdef MIPS_BNE_EN
    S_JUMP     = 4'd11,
    S_BRANCHNE = 4'd12
`else
    S_JUMP     = 4'd11
`endif
  } state_t;

  // fetch_wr marks FETCH; the top qualifies it with mem_ready to form the IR/PC strobes.
  typedef struct packed {
    logic       fetch_wr;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MIPS_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/main_control_decode.sv
// Moore output decode: maps the state register to the control bundle; unknown encodings give all zeros.
// Macro MIPS_BNE_EN adds the BRANCHNE decode.
module main_control_decode
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      STATE_W'(S_FETCH): begin
        ctrl.fetch_wr  = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      STATE_W'(S_DECODE): ctrl.alu_src_b = SRCB_BOFF;
      STATE_W'(S_MEMADR): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      STATE_W'(S_MEMRD): begin
        ctrl.ior_d    = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      STATE_W'(S_MEMWR): begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      STATE_W'(S_MEMWB): begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      STATE_W'(S_EXEC): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      STATE_W'(S_BRANCH): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
`ifdef MIPS_BNE_EN
      STATE_W'(S_BRANCHNE): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
`endif
      STATE_W'(S_ADDIEX): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      STATE_W'(S_ADDIWB): ctrl.reg_write = 1'b1;
      STATE_W'(S_JUMP): begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: next-state register here, output decode in main_control_decode.
// Macro MIPS_BNE_EN enables the bne instruction (BRANCHNE state, BranchNe output).
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               Branch,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               illegal_op,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [1:0]         ALUOpcode,
  output logic [STATE_W-1:0] dbg_state
);

  logic [STATE_W-1:0] state_q;
  ctrl_t              ctrl;
  logic               fetch_done;

  // Memory handshake: the FSM holds MemRead/MemWrite steady in FETCH, MEMRD and MEMWR;
  // the access completes on the rising edge where mem_ready=1, and only then does the state advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_W'(S_FETCH);
    end else begin
      case (state_q)
        STATE_W'(S_FETCH):  if (mem_ready) state_q <= STATE_W'(S_DECODE);
        STATE_W'(S_DECODE): begin
          case (op)
            OP_LW, OP_SW: state_q <= STATE_W'(S_MEMADR);
            OP_RTYPE:     state_q <= STATE_W'(S_EXEC);
            OP_BEQ:       state_q <= STATE_W'(S_BRANCH);
            OP_ADDI:      state_q <= STATE_W'(S_ADDIEX);
            OP_J:         state_q <= STATE_W'(S_JUMP);
`ifdef MIPS_BNE_EN
            OP_BNE:       state_q <= STATE_W'(S_BRANCHNE);
`endif
            default:      state_q <= STATE_W'(S_FETCH);
          endcase
        end
        STATE_W'(S_MEMADR): state_q <= (op == OP_SW) ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
        STATE_W'(S_MEMRD):  if (mem_ready) state_q <= STATE_W'(S_MEMWB);
        STATE_W'(S_MEMWR):  if (mem_ready) state_q <= STATE_W'(S_FETCH);
        STATE_W'(S_EXEC):   state_q <= STATE_W'(S_ALUWB);
        STATE_W'(S_ADDIEX): state_q <= STATE_W'(S_ADDIWB);
        default:            state_q <= STATE_W'(S_FETCH);
      endcase
    end
  end

  main_control_decode #(.STATE_W(STATE_W)) u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // IR/PC update happens only on the fetch beat that actually completes.
  assign fetch_done = ctrl.fetch_wr & mem_ready & ~rst;

  assign PCWrite    = ctrl.pc_write | fetch_done;
  assign IRWrite    = fetch_done;
  assign Branch     = ctrl.branch;
  assign BranchNe   = ctrl.branch_ne;
  assign IorD       = ctrl.ior_d;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign MemtoReg   = ctrl.memto_reg;
  assign RegDst     = ctrl.reg_dst;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign PCSrc      = ctrl.pc_src;
  assign ALUOpcode  = ctrl.alu_op;
  assign illegal_op = (state_q == STATE_W'(S_DECODE)) && !op_legal(op);
  assign dbg_state  = state_q;

endmodule
